uart_tx_datapath: RTL and testbench
===================================

Name: uart_tx_datapath

Overview:
- Transmit datapath for the UART transmitter. Sits directly downstream of the transmitter controller FSM.
- Consumes the controller's load and baud_enable strobes and generates the bit-rate tick.
- Serialises one 11-bit frame (start, 8 data LSB-first, parity, stop) onto tx.
- Returns bit_counter to the controller, which ends TRANS when bit_counter reaches 11.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD, 9600: line bit rate.
- DIVISOR, CLK_FREQ/BAUD (integer division): clock cycles per bit. Legal range is 2..65535.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd parity.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  one-cycle strobe from controller; captures data_in and starts a frame.
- baud_enable  input  1  enables the baud counter; low means pause.
- data_in  input  8  byte to transmit; sampled only when load=1.
- tx  output  1  serial line; idles high.
- bit_counter  output  4  number of bits completed in current frame, 0..11.
- baud_tick  output  1  one-cycle pulse at each bit boundary.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset values (one clk edge with reset=1):
  - tx=1, shift register all ones, bit_counter=0, baud counter=0, baud_tick=0, busy=0.
  - Reset has priority over every other input.
- Baud counter:
  - 16-bit counter.
  - When baud_enable=0 or load=1: counter clears to 0 next cycle and baud_tick=0.
  - Otherwise the counter increments each cycle.
  - baud_tick is registered and asserted for the cycle after the counter equals DIVISOR-1. That same edge wraps the counter to 0.
  - Result: each bit is held exactly DIVISOR cycles while enabled.
- Frame load:
  - On load=1, the 11-bit shift register takes {1'b1 stop, parity, data_in[7:0], 1'b0 start}.
  - parity = XOR(data_in) XOR PARITY_ODD.
  - Same edge: bit_counter becomes 0 and busy becomes 1.
  - tx shows the start bit (0) from the cycle after load.
- tx output:
  - tx is the registered shift register bit 0.
  - It changes only on load, on a tick shift, or on reset.
- Shift on baud_tick (while bit_counter<11):
  - Shift right, filling the MSB with 1.
  - bit_counter increments.
  - When bit_counter becomes 11, busy clears on the same edge.
  - tx is then 1 (line idle).
- Saturation: with bit_counter=11, ticks neither shift nor increment; tx stays 1.
- Frame timing: with continuous baud_enable, bit_counter reaches 11 exactly 11*DIVISOR cycles after the load edge.
- Simultaneous load and tick: load wins. The frame restarts with bit_counter=0 and the counter cleared.
- Load mid-frame: the current frame is aborted and the new frame starts immediately. There is no stop-bit guarantee for the aborted frame.
- baud_enable deasserted mid-frame:
  - Counter clears; tx and bit_counter hold.
  - On re-enable, the current bit gets a full DIVISOR cycles from re-enable.
- Reset mid-frame: tx=1, bit_counter=0 and busy=0 on the next cycle. The partial frame is discarded.
- Implementation constraints: no combinational path from any input to tx, busy or bit_counter; all outputs are registered.

Test Plan (CLK_FREQ=1600, BAUD=100, so DIVISOR=16, unless noted):
1. Reset: hold reset 2 cycles with random load/data_in → tx=1, bit_counter=0, busy=0, baud_tick=0 after the first edge.
2. Normal frame: load with data_in=0xA5, baud_enable=1 held → tx sequence 0,1,0,1,0,0,1,0,1,0,1 (even parity 0), each bit 16 cycles. bit_counter=11 and busy=0 exactly 176 cycles after the load edge. Exactly 11 baud_tick pulses occur.
3. Parity: data_in=0x01 with PARITY_ODD=0 → parity bit 1. Same data with PARITY_ODD=1 → parity bit 0. data_in=0x00, even → parity bit 0.
4. Pause: drop baud_enable for 40 cycles during data bit 3 → no baud_tick and tx/bit_counter held. After re-enable, bit 3 lasts 16 further cycles. Total frame takes 176 enabled cycles.
5. Restart: assert load with 0x3C while bit_counter=5 → next cycle tx=0, bit_counter=0, busy=1. The 0x3C frame then completes normally.
6. Reset mid-frame at bit_counter=7 → next cycle tx=1, bit_counter=0, busy=0. A subsequent load transmits a clean full frame.

Source files
------------

// File: rtl/uart_tx_datapath.sv
// UART transmit datapath: baud tick generation and 11-bit frame serialiser.
// Ports: clk, reset (sync, active-high), load, baud_enable, data_in[7:0] in;
//        tx, bit_counter[3:0], baud_tick, busy out (all registered).
module uart_tx_datapath #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int DIVISOR    = CLK_FREQ / BAUD,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       baud_enable,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic [3:0] bit_counter,
    output logic       baud_tick,
    output logic       busy
);

    localparam logic [15:0] LAST  = 16'(DIVISOR - 1);
    localparam logic [3:0]  NBITS = 4'd11;

    logic [15:0] baud_cnt;
    logic [10:0] shreg;
    logic        bit_end;
    logic        parity;

    // The shift happens on the same edge that raises baud_tick, so each
    // bit is held exactly DIVISOR enabled cycles.
    assign bit_end = baud_enable && !load && (baud_cnt == LAST);
    assign parity  = (^data_in) ^ PARITY_ODD;
    assign tx      = shreg[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt  <= '0;
            baud_tick <= 1'b0;
        end else if (!baud_enable || load) begin
            baud_cnt  <= '0;
            baud_tick <= 1'b0;
        end else if (baud_cnt == LAST) begin
            baud_cnt  <= '0;
            baud_tick <= 1'b1;
        end else begin
            baud_cnt  <= baud_cnt + 16'd1;
            baud_tick <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg       <= '1;
            bit_counter <= '0;
            busy        <= 1'b0;
        end else if (load) begin
            shreg       <= {1'b1, parity, data_in, 1'b0};
            bit_counter <= '0;
            busy        <= 1'b1;
        end else if (bit_end && (bit_counter < NBITS)) begin
            // MSB refills with 1 so the line idles high after the stop bit.
            shreg       <= {1'b1, shreg[10:1]};
            bit_counter <= bit_counter + 4'd1;
            busy        <= (bit_counter != (NBITS - 4'd1));
        end
    end

endmodule

// File: tb/tb_uart_tx_datapath.sv
// Self-checking bench for uart_tx_datapath (DIVISOR=16, even and odd parity
// instances driven in parallel).
module tb_uart_tx_datapath;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic       baud_enable;
    logic [7:0] data_in;
    logic       tx0, tx1, tick0, tick1, busy0, busy1;
    logic [3:0] bc0, bc1;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] data;
        logic       par_e;
        logic       par_o;
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;

    uart_tx_datapath #(.CLK_FREQ(1600), .BAUD(100), .PARITY_ODD(1'b0)) u_even (
        .clk(clk), .reset(reset), .load(load), .baud_enable(baud_enable),
        .data_in(data_in), .tx(tx0), .bit_counter(bc0), .baud_tick(tick0),
        .busy(busy0)
    );

    uart_tx_datapath #(.CLK_FREQ(1600), .BAUD(100), .PARITY_ODD(1'b1)) u_odd (
        .clk(clk), .reset(reset), .load(load), .baud_enable(baud_enable),
        .data_in(data_in), .tx(tx1), .bit_counter(bc1), .baud_tick(tick1),
        .busy(busy1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [7:0] d);
        load    = 1'b1;
        data_in = d;
        step();
        load    = 1'b0;
        data_in = 8'($urandom);
        chk("load_tx", 32'(tx0), 32'd0);
        chk("load_bc", 32'(bc0), 32'd0);
        chk("load_busy", 32'({busy0, busy1}), 32'd3);
    endtask

    // Runs the 176 cycles following a load edge and checks the whole frame.
    task automatic finish_frame(input logic [7:0] d, input logic pe,
                                input logic po);
        logic [10:0] fe, fo, got_e, got_o;
        int ticks;
        fe    = {1'b1, pe, d, 1'b0};
        fo    = {1'b1, po, d, 1'b0};
        got_e = '0;
        got_o = '0;
        ticks = 0;
        for (int k = 1; k <= 176; k++) begin
            step();
            if (tick0) ticks++;
            if (k % 16 == 8) begin
                got_e[k / 16] = tx0;
                got_o[k / 16] = tx1;
            end
            if (k == 175) begin
                chk("bc_before_end", 32'(bc0), 32'd10);
                chk("busy_before_end", 32'(busy0), 32'd1);
            end
        end
        chk("frame_even", 32'(got_e), 32'(fe));
        chk("frame_odd", 32'(got_o), 32'(fo));
        chk("end_bc", 32'({bc0, bc1}), 32'hBB);
        chk("end_busy", 32'({busy0, busy1}), 32'd0);
        chk("end_tx", 32'({tx0, tx1}), 32'd3);
        chk("tick_count", 32'(ticks), 32'd11);
    endtask

    initial begin
        int en_cnt;
        int n;
        int bad;
        logic held;

        tbl[0] = '{8'hA5, 1'b0, 1'b1};
        tbl[1] = '{8'h01, 1'b1, 1'b0};
        tbl[2] = '{8'h00, 1'b0, 1'b1};
        tbl[3] = '{8'h3C, 1'b0, 1'b1};
        tbl[4] = '{8'hFF, 1'b0, 1'b1};
        tbl[5] = '{8'h80, 1'b1, 1'b0};
        tbl[6] = '{8'h07, 1'b1, 1'b0};
        tbl[7] = '{8'h6E, 1'b1, 1'b0};

        reset       = 1'b1;
        load        = 1'($urandom);
        data_in     = 8'($urandom);
        baud_enable = 1'b1;
        step();
        chk("rst_tx", 32'({tx0, tx1}), 32'd3);
        chk("rst_bc", 32'(bc0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_tick", 32'(tick0), 32'd0);
        load    = 1'($urandom);
        data_in = 8'($urandom);
        step();
        reset = 1'b0;
        load  = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            do_load(tbl[i].data);
            finish_frame(tbl[i].data, tbl[i].par_e, tbl[i].par_o);
        end

        // Saturation: further ticks neither shift nor count.
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bc0 != 4'd11 || tx0 != 1'b1 || busy0) bad++;
        end
        chk("saturate", 32'(bad), 32'd0);

        // Restart mid-frame at bit_counter=5.
        do_load(8'hA5);
        for (int i = 0; i < 400 && bc0 != 4'd5; i++) step();
        chk("reach_bc5", 32'(bc0), 32'd5);
        do_load(8'h3C);
        finish_frame(8'h3C, 1'b0, 1'b1);

        // Reset mid-frame at bit_counter=7.
        do_load(8'hC3);
        for (int i = 0; i < 400 && bc0 != 4'd7; i++) step();
        chk("reach_bc7", 32'(bc0), 32'd7);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_tx", 32'(tx0), 32'd1);
        chk("midrst_bc", 32'(bc0), 32'd0);
        chk("midrst_busy", 32'(busy0), 32'd0);
        step();
        do_load(8'h5A);
        finish_frame(8'h5A, 1'b0, 1'b1);

        // Pause for 40 cycles at the start of data bit 3.
        do_load(8'h6B);
        en_cnt = 0;
        for (int i = 0; i < 400 && bc0 != 4'd4; i++) begin
            step();
            en_cnt++;
        end
        chk("pause_reach", 32'(en_cnt), 32'd64);
        baud_enable = 1'b0;
        held        = tx0;
        bad         = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (tick0 || bc0 != 4'd4 || tx0 != held) bad++;
        end
        chk("pause_hold", 32'(bad), 32'd0);
        baud_enable = 1'b1;
        n = 0;
        for (int i = 0; i < 400 && bc0 != 4'd5; i++) begin
            step();
            n++;
            en_cnt++;
        end
        chk("pause_bit_len", 32'(n), 32'd16);
        for (int i = 0; i < 400 && bc0 != 4'd11; i++) begin
            step();
            en_cnt++;
        end
        chk("pause_total", 32'(en_cnt), 32'd176);
        chk("pause_busy", 32'(busy0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
